// File: rtl/logip_trg_pkg.sv
// Shared field positions, stage configuration type and level helper for the trigger sequencer.
// Optional feature macro: LOGIP_TRG_DELAY_EN (per-stage strobe delay counters).
package logip_trg_pkg;

    localparam int unsigned LEVEL_W       = 2;
    localparam int unsigned DELAY_W       = 16;
    localparam int unsigned CMD_DELAY_LSB = 0;
    localparam int unsigned CMD_LEVEL_LSB = 16;
    localparam int unsigned CMD_START_BIT = 27;

    typedef struct packed {
        logic [DELAY_W-1:0] delay;
        logic [LEVEL_W-1:0] level;
        logic               start;
    } stage_cfg_t;

    // Level advance that saturates at the top level.
    function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] lvl);
        return (lvl == '1) ? lvl : lvl + LEVEL_W'(1);
    endfunction

endpackage

// File: rtl/trg_stage.sv
// One trigger stage: mask/value/config registers, sample compare and optional delay counter.
// Optional feature macro: LOGIP_TRG_DELAY_EN.
module trg_stage
    import logip_trg_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter stage_cfg_t  RST_CFG = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   cmd_i,
    input  logic               set_mask_i,
    input  logic               set_val_i,
    input  logic               set_cfg_i,
    input  logic               armed_i,
    input  logic [LEVEL_W-1:0] level_i,
    input  logic               clr_i,
    input  logic               stb_i,
    input  logic [WIDTH-1:0]   smpls_i,
    output logic               fire_c_o,
    output logic               start_o
);

    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] val_q, val_d;
    stage_cfg_t       cfg_q, cfg_d;
    logic             match_c;
    logic             active_c;
    logic             fire_c;

    assign match_c  = ((smpls_i & mask_q) == (val_q & mask_q));
    assign fire_c_o = fire_c;
    assign start_o  = cfg_q.start;

    always_comb begin
        mask_d = mask_q;
        val_d  = val_q;
        cfg_d  = cfg_q;
        if (set_mask_i) mask_d = cmd_i;
        if (set_val_i)  val_d  = cmd_i;
        if (set_cfg_i) begin
            cfg_d.delay = cmd_i[CMD_DELAY_LSB +: DELAY_W];
            cfg_d.level = cmd_i[CMD_LEVEL_LSB +: LEVEL_W];
            cfg_d.start = cmd_i[CMD_START_BIT];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q <= '0;
            val_q  <= '0;
            cfg_q  <= RST_CFG;
        end else begin
            mask_q <= mask_d;
            val_q  <= val_d;
            cfg_q  <= cfg_d;
        end
    end

`ifdef LOGIP_TRG_DELAY_EN
    logic               cnt_on_q, cnt_on_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;

    assign active_c = armed_i && (cfg_q.level == level_i) && !cnt_on_q;

    // Match loads delay-1 so that delay d fires on the (d+1)-th strobe including the match.
    always_comb begin
        fire_c   = 1'b0;
        cnt_on_d = cnt_on_q;
        cnt_d    = cnt_q;
        if (armed_i && stb_i) begin
            if (cnt_on_q) begin
                if (cnt_q == '0) begin
                    fire_c   = 1'b1;
                    cnt_on_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - DELAY_W'(1);
                end
            end else if (active_c && match_c) begin
                if (cfg_q.delay == '0) begin
                    fire_c = 1'b1;
                end else begin
                    cnt_on_d = 1'b1;
                    cnt_d    = cfg_q.delay - DELAY_W'(1);
                end
            end
        end
        if (clr_i || !armed_i) begin
            cnt_on_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_on_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cnt_on_q <= cnt_on_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    logic unused_c;

    // Delay is stored for readback compatibility but has no effect in this build.
    assign unused_c = ^{clr_i, cfg_q.delay};
    assign active_c = armed_i && (cfg_q.level == level_i);
    assign fire_c   = active_c && stb_i && match_c;
`endif

endmodule

// File: rtl/trigger_seq.sv
// Multi-stage trigger sequencer: owns arm state, trigger level and the run pulse.
// Optional feature macro: LOGIP_TRG_DELAY_EN (enables per-stage delay counting in trg_stage).
module trigger_seq
    import logip_trg_pkg::*;
#(
    parameter int unsigned STAGES = 4,
    parameter int unsigned WIDTH  = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   cmd_i,
    input  logic [1:0]         stage_i,
    input  logic               set_mask_i,
    input  logic               set_val_i,
    input  logic               set_cfg_i,
    input  logic               arm_i,
    input  logic               stb_i,
    input  logic [WIDTH-1:0]   smpls_i,
    output logic               run_o,
    output logic               armed_o,
    output logic [LEVEL_W-1:0] level_o
);

    localparam stage_cfg_t CFG_FIRST = '{delay: '0, level: '0, start: 1'b1};
    localparam stage_cfg_t CFG_OTHER = '{delay: '0, level: '1, start: 1'b0};

    logic [STAGES-1:0]  fire_c;
    logic [STAGES-1:0]  start_c;
    logic               start_fire_c;
    logic               step_fire_c;
    logic               clr_c;
    logic               run_q, run_d;
    logic               armed_q, armed_d;
    logic [LEVEL_W-1:0] level_q, level_d;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        trg_stage #(
            .WIDTH   (WIDTH),
            .RST_CFG ((g == 0) ? CFG_FIRST : CFG_OTHER)
        ) u_stage (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .cmd_i      (cmd_i),
            .set_mask_i (set_mask_i && (stage_i == 2'(g))),
            .set_val_i  (set_val_i  && (stage_i == 2'(g))),
            .set_cfg_i  (set_cfg_i  && (stage_i == 2'(g))),
            .armed_i    (armed_q),
            .level_i    (level_q),
            .clr_i      (clr_c),
            .stb_i      (stb_i),
            .smpls_i    (smpls_i),
            .fire_c_o   (fire_c[g]),
            .start_o    (start_c[g])
        );
    end

    assign start_fire_c = |(fire_c & start_c);
    assign step_fire_c  = |(fire_c & ~start_c);
    assign clr_c        = arm_i || start_fire_c;

    // Arm beats a start firing, which beats a level step; run still pulses on a start firing.
    always_comb begin
        run_d   = start_fire_c;
        armed_d = armed_q;
        level_d = level_q;
        if (arm_i) begin
            armed_d = 1'b1;
            level_d = '0;
        end else if (start_fire_c) begin
            armed_d = 1'b0;
            level_d = '0;
        end else if (step_fire_c) begin
            level_d = level_inc(level_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q   <= 1'b0;
            armed_q <= 1'b0;
            level_q <= '0;
        end else begin
            run_q   <= run_d;
            armed_q <= armed_d;
            level_q <= level_d;
        end
    end

    assign run_o   = run_q;
    assign armed_o = armed_q;
    assign level_o = level_q;

endmodule
